vr_rr_arb: RTL and testbench
============================

# vr_rr_arb

Round-robin arbiter that shares one valid/ready payload channel among NUM_REQ requesters. It feeds a registered, forward-type output stage. Multi-beat packets are supported: once a requester's first beat is accepted, the grant is held until its `s_last` beat. The block sits in front of a shared register slice or downstream port, replacing ad-hoc muxing of several valid/ready sources.

## Interface
- NUM_REQ, 4: number of requesters; legal range 1..32.
- PLD_TYPE, logic: payload type, shared by all requesters and the output.
- NO_DATA_RESET, 1'b0: when 1, `m_pld` has no reset; it is X until the first load.
- IDW (localparam): max($clog2(NUM_REQ), 1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_pld  in  PLD_TYPE[NUM_REQ]  per-requester payload.
- s_vld  in  NUM_REQ  per-requester valid.
- s_last  in  NUM_REQ  per-requester end-of-packet; qualified by s_vld.
- s_rdy  out  NUM_REQ  per-requester ready; one-hot or zero.
- m_pld  out  PLD_TYPE  registered payload.
- m_vld  out  1  registered valid.
- m_last  out  1  registered end-of-packet.
- m_src_id  out  IDW  index of the requester that sourced the current output beat.
- m_rdy  in  1  downstream ready.

## Operation
- **Reset values:** m_vld=0, m_last=0, m_src_id=0, m_pld=0 (subject to NO_DATA_RESET), ptr=0, lock=0, lock_id=0, rst_lock_n=0.
- **rst_lock_n:** goes to 1 on the first clock after reset deasserts. While it is 0, s_rdy is all zeros.
- **Load enable:** out_en = (~m_vld | m_rdy) & rst_lock_n.
- **Grant selection (combinational):**
  - If lock=1: gnt = lock_id, and gnt_vld = s_vld[lock_id].
  - Otherwise: gnt is the first i with s_vld[i]=1, scanning ptr, ptr+1, … mod NUM_REQ. gnt_vld = |s_vld.
- **Ready:** s_rdy[i] = out_en & gnt_vld & (gnt==i).
- **Transfer:** xfer = |(s_vld & s_rdy). On xfer, the output registers load s_pld[gnt], s_last[gnt] and gnt, and set m_vld=1.
- **Drain:** if m_vld & m_rdy & ~xfer, then m_vld goes to 0. m_pld, m_last and m_src_id hold.
- **Packet lock:**
  - On xfer with s_last[gnt]=0: lock goes to 1 and lock_id takes gnt.
  - On xfer with s_last[gnt]=1: lock goes to 0 and ptr takes (gnt+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0.
  - ptr changes only at packet end. Single-beat packets always have s_last=1.
- **Locked requester idle:** if the locked requester drops s_vld mid-packet, no other requester is granted. Bubbles are inserted until the packet resumes.
- **Protocol requirements on requesters:**
  - s_vld must not depend on s_rdy.
  - Once s_vld is asserted, s_pld and s_last hold until the beat is accepted.
  - Output m_* obey the same rules toward downstream.
- **NUM_REQ=1:** ptr stays 0. The block reduces to a forward slice with packet tracking.
- **Asynchronous reset mid-packet:** all state returns to its reset values. The partial packet is dropped and the lock is cleared.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on m_* after edge N and stays until m_rdy.
- Throughput is 1 beat/cycle when m_rdy=1 continuously. Simultaneous drain and load in the same cycle are required.
- With m_vld=1 and m_rdy=0: s_rdy is all 0, and m_* are stable.
- Arbitration is work-conserving. With no lock held, the grant moves to the next valid requester in the same cycle the previous packet's last beat transfers, with no idle cycle.
- Ready depends combinationally on s_vld, lock, ptr, m_vld and m_rdy. There is no combinational path from s_pld to any output.
- s_rdy is all 0 in the first cycle after rst_n deasserts, even if m_rdy=1.

## Test plan
- **Reset:** assert rst_n=0 mid-traffic → all m_* and s_rdy are 0 immediately. After deassert, the first cycle has s_rdy=0 and the second cycle has s_rdy[0]=1 with s_vld[0]=1 and m_rdy=1.
- **Fairness:** NUM_REQ=4, all s_vld=1, single-beat packets, m_rdy=1 → m_src_id sequence is 0,1,2,3,0,1,… with m_vld=1 every cycle.
- **Packet lock:** req1 sends a 3-beat packet (last on beat 3) while req2 and req3 are valid → m_src_id is 1,1,1,2,3. s_rdy[2] stays 0 until req1's last beat is accepted.
- **Mid-packet bubble:** req0 drops s_vld for 2 cycles after beat 1 while req3 is valid → 2 idle cycles (m_vld=0), then req0 beat 2, then req3.
- **Backpressure:** m_rdy=0 for 5 cycles with m_vld=1 → m_pld, m_last and m_src_id are unchanged and s_rdy is all 0. When m_rdy returns to 1, beats continue with no loss or duplication (scoreboard per source).
- **Wrap and sparse requests:** ptr=3, only req3 and req0 valid, single-beat packets → grant order is 3,0,3,0.

Source files
------------

// File: rtl/vr_rr_arb.sv
// Round-robin arbiter over NUM_REQ valid/ready sources feeding a registered forward slice.
// Multi-beat packets hold the grant from the first accepted beat until the s_last beat.
module vr_rr_arb #(
  parameter int  NUM_REQ       = 4,
  parameter type PLD_TYPE      = logic,
  parameter bit  NO_DATA_RESET = 1'b0,
  localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  PLD_TYPE            s_pld [NUM_REQ],
  input  logic [NUM_REQ-1:0] s_vld,
  input  logic [NUM_REQ-1:0] s_last,
  output logic [NUM_REQ-1:0] s_rdy,
  output PLD_TYPE            m_pld,
  output logic               m_vld,
  output logic               m_last,
  output logic [IDW-1:0]     m_src_id,
  input  logic               m_rdy
);

  logic               rst_lock_n;
  logic               lock;
  logic [IDW-1:0]     lock_id;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_nxt;
  logic [NUM_REQ-1:0] vld_rot;
  logic [IDW:0]       idx_sum;
  logic [IDW-1:0]     rr_gnt;
  logic [IDW-1:0]     gnt;
  logic               gnt_vld;
  logic               gnt_last;
  PLD_TYPE            gnt_pld;
  logic               out_en;
  logic               xfer;

  assign out_en = (~m_vld | m_rdy) & rst_lock_n;

  // Rotate valids so bit 0 is the pointer position; the lowest set bit of the
  // rotated vector is the winner, mapped back to an absolute index modulo NUM_REQ.
  always_comb begin
    vld_rot = NUM_REQ'({s_vld, s_vld} >> ptr);
    rr_gnt  = '0;
    idx_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        idx_sum = {1'b0, ptr} + (IDW+1)'(k);
        if (idx_sum >= (IDW+1)'(NUM_REQ)) begin
          idx_sum = idx_sum - (IDW+1)'(NUM_REQ);
        end
        rr_gnt = idx_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    if (lock) begin
      gnt     = lock_id;
      gnt_vld = s_vld[lock_id];
    end else begin
      gnt     = rr_gnt;
      gnt_vld = |s_vld;
    end
  end

  always_comb begin
    s_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_rdy[i] = out_en & gnt_vld & (gnt == IDW'(i));
    end
  end

  assign xfer     = |(s_vld & s_rdy);
  assign gnt_pld  = s_pld[gnt];
  assign gnt_last = s_last[gnt];
  assign ptr_nxt  = (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + IDW'(1);

  // Holds s_rdy low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_lock_n <= 1'b0;
    end else begin
      rst_lock_n <= 1'b1;
    end
  end

  // A load and a drain in the same cycle resolve to a load, keeping 1 beat/cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld    <= 1'b0;
      m_last   <= 1'b0;
      m_src_id <= '0;
      ptr      <= '0;
      lock     <= 1'b0;
      lock_id  <= '0;
    end else if (xfer) begin
      m_vld    <= 1'b1;
      m_last   <= gnt_last;
      m_src_id <= gnt;
      if (gnt_last) begin
        lock <= 1'b0;
        ptr  <= ptr_nxt;
      end else begin
        lock    <= 1'b1;
        lock_id <= gnt;
      end
    end else if (m_vld & m_rdy) begin
      m_vld <= 1'b0;
    end
  end

  if (NO_DATA_RESET) begin : g_pld_nrst
    always_ff @(posedge clk) begin
      if (xfer) begin
        m_pld <= gnt_pld;
      end
    end
  end else begin : g_pld_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_pld <= '0;
      end else if (xfer) begin
        m_pld <= gnt_pld;
      end
    end
  end

endmodule

// File: tb/tb_vr_rr_arb.sv
// Self-checking bench for vr_rr_arb: table of per-cycle vectors plus a per-beat
// scoreboard on the payload, and a hand-written asynchronous reset mid-packet.
module tb_vr_rr_arb;

  localparam int NR = 4;

  typedef struct packed {
    logic [3:0] vld;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_mvld;
    logic [1:0] exp_id;
  } vec_t;

  typedef struct {
    int         src;
    logic [7:0] pld;
    logic       last;
  } sb_item_t;

  logic          clk;
  logic          rst_n;
  logic [7:0]    s_pld [NR];
  logic [NR-1:0] s_vld;
  logic [NR-1:0] s_last;
  logic [NR-1:0] s_rdy;
  logic [7:0]    m_pld;
  logic          m_vld;
  logic          m_last;
  logic [1:0]    m_src_id;
  logic          m_rdy;

  int         tests_run;
  int         tests_failed;
  logic [5:0] beat_cnt [NR];
  logic       exp_mvld_q;
  sb_item_t   sb [$];
  vec_t       tbl [$];

  vr_rr_arb #(
    .NUM_REQ       (NR),
    .PLD_TYPE      (logic [7:0]),
    .NO_DATA_RESET (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_pld    (s_pld),
    .s_vld    (s_vld),
    .s_last   (s_last),
    .s_rdy    (s_rdy),
    .m_pld    (m_pld),
    .m_vld    (m_vld),
    .m_last   (m_last),
    .m_src_id (m_src_id),
    .m_rdy    (m_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] last, input logic rdy,
                              input logic [3:0] er, input logic em, input logic [1:0] eid);
    vec_t v;
    v.vld      = vld;
    v.last     = last;
    v.rdy      = rdy;
    v.exp_rdy  = er;
    v.exp_mvld = em;
    v.exp_id   = eid;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one cycle, checks ready before the edge and the
  // registered outputs after it, and returns at the following negedge.
  task automatic applyStimulus(input vec_t v);
    sb_item_t it;
    s_vld  = v.vld;
    s_last = v.last;
    m_rdy  = v.rdy;
    for (int i = 0; i < NR; i++) s_pld[i] = {2'(i), beat_cnt[i]};
    #1;
    checkOutput("s_rdy", 32'(s_rdy), 32'(v.exp_rdy));
    if (exp_mvld_q && v.rdy) begin
      if (sb.size() == 0) checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
      else void'(sb.pop_front());
    end
    for (int i = 0; i < NR; i++) begin
      if (v.exp_rdy[i]) begin
        it.src  = i;
        it.pld  = s_pld[i];
        it.last = v.last[i];
        sb.push_back(it);
        beat_cnt[i] = beat_cnt[i] + 6'd1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("m_vld", 32'(m_vld), 32'(v.exp_mvld));
    checkOutput("m_src_id", 32'(m_src_id), 32'(v.exp_id));
    if (v.exp_mvld) begin
      if (sb.size() != 1) begin
        checkOutput("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        checkOutput("m_pld", 32'(m_pld), 32'(sb[0].pld));
        checkOutput("m_last", 32'(m_last), 32'(sb[0].last));
        checkOutput("sb_src", 32'(m_src_id), 32'(sb[0].src));
      end
    end
    exp_mvld_q = v.exp_mvld;
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_mvld_q   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      beat_cnt[i] = '0;
      s_pld[i]    = '0;
    end

    // Reset release and fairness: ids 0,1,2,3,0, then drain (ptr ends at 1).
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3));
    tbl.push_back(mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0));
    // Packet lock: req1 three beats while req2/req3 wait, then 2, 3.
    tbl.push_back(mk(4'b1110, 4'b1100, 1'b1, 4'b0010, 1'b1, 2'd1));
    tbl.push_back(mk(4'b1110, 4'b1100, 1'b1, 4'b0010, 1'b1, 2'd1));
    tbl.push_back(mk(4'b1110, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1));
    tbl.push_back(mk(4'b1100, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2));
    tbl.push_back(mk(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3));
    // Mid-packet bubble: req0 idles two cycles while req3 must not be granted.
    tbl.push_back(mk(4'b1001, 4'b1000, 1'b1, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0));
    tbl.push_back(mk(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3));
    // Backpressure: five stalled cycles with the beat held, then resume.
    tbl.push_back(mk(4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0));
    for (int c = 0; c < 5; c++) tbl.push_back(mk(4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2));
    tbl.push_back(mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0));
    // Wrap with sparse requests: move ptr to 3, then grants 3,0,3,0.
    tbl.push_back(mk(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2));
    tbl.push_back(mk(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3));
    tbl.push_back(mk(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3));
    tbl.push_back(mk(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0));

    rst_n  = 1'b0;
    s_vld  = 4'b1111;
    s_last = 4'b1111;
    m_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_s_rdy", 32'(s_rdy), 32'd0);
    checkOutput("reset_m_vld", 32'(m_vld), 32'd0);
    checkOutput("reset_m_last", 32'(m_last), 32'd0);
    checkOutput("reset_m_src_id", 32'(m_src_id), 32'd0);
    checkOutput("reset_m_pld", 32'(m_pld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < tbl.size(); n++) applyStimulus(tbl[n]);

    // Asynchronous reset in the middle of a locked req1 packet.
    applyStimulus(mk(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_m_vld", 32'(m_vld), 32'd0);
    checkOutput("async_m_last", 32'(m_last), 32'd0);
    checkOutput("async_m_src_id", 32'(m_src_id), 32'd0);
    checkOutput("async_m_pld", 32'(m_pld), 32'd0);
    checkOutput("async_s_rdy", 32'(s_rdy), 32'd0);
    sb.delete();
    exp_mvld_q = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0));
    applyStimulus(mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0));
    applyStimulus(mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0));
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
